// File: rtl/uart_tx_param_if.sv
// Handshake and serial-line bundle for uart_tx_param.
// The send_break signal exists only when UART_TX_BREAK_EN is defined.
interface uart_tx_param_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      Data_Valid;
  logic [DATA_WIDTH-1:0]     P_Data;
  logic                      par_en;
  logic                      PAR_TYP;
  logic                      stop2;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      TX_OUT;
  logic                      busy;
  logic                      frame_done;
`ifdef UART_TX_BREAK_EN
  logic                      send_break;
`endif

  modport master (
`ifdef UART_TX_BREAK_EN
    output send_break,
`endif
    output Data_Valid, P_Data, par_en, PAR_TYP, stop2, prescale,
    input  TX_OUT, busy, frame_done
  );

  modport slave (
`ifdef UART_TX_BREAK_EN
    input  send_break,
`endif
    input  Data_Valid, P_Data, par_en, PAR_TYP, stop2, prescale,
    output TX_OUT, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stops.
// Define UART_TX_BREAK_EN to add the send_break input and a line-break state.
module uart_tx_param #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_param_if.slave bus
);
  localparam int IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
`ifdef UART_TX_BREAK_EN
  localparam logic [IDX_W-1:0] BRK_BITS  = IDX_W'(DATA_WIDTH + 3);
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
    , BRK, BRK_STOP
`endif
  } state_t;

  state_t                    state_reg, state_next;
  logic [PRESCALE_WIDTH-1:0] bit_cnt_reg, cnt_next;
  logic [IDX_W-1:0]          bit_idx_reg, idx_next;
  logic [DATA_WIDTH-1:0]     data_reg, data_next;
  logic [DATA_WIDTH-1:0]     shift_reg, shift_next;
  logic                      par_en_reg, par_en_next;
  logic                      par_typ_reg, par_typ_next;
  logic                      stop2_reg, stop2_next;
  logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
  logic                      tx_reg, tx_next;
  logic                      busy_reg, busy_next;
  logic                      done_reg, done_next;

  logic [PRESCALE_WIDTH-1:0] p_last;
  logic                      bit_end;
  logic                      par_bit;

  // A prescale of 0 behaves like 1, so the last count is 0 in both cases.
  assign p_last  = (prescale_reg == '0) ? '0 : prescale_reg - 1'b1;
  assign bit_end = (bit_cnt_reg == p_last);
  assign par_bit = (^data_reg) ^ par_typ_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      bit_idx_reg  <= '0;
      data_reg     <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_typ_reg  <= 1'b0;
      stop2_reg    <= 1'b0;
      prescale_reg <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= cnt_next;
      bit_idx_reg  <= idx_next;
      data_reg     <= data_next;
      shift_reg    <= shift_next;
      par_en_reg   <= par_en_next;
      par_typ_reg  <= par_typ_next;
      stop2_reg    <= stop2_next;
      prescale_reg <= prescale_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Every output is computed one edge early so TX_OUT, busy and frame_done leave flops.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = bit_cnt_reg;
    idx_next      = bit_idx_reg;
    data_next     = data_reg;
    shift_next    = shift_reg;
    par_en_next   = par_en_reg;
    par_typ_next  = par_typ_reg;
    stop2_next    = stop2_reg;
    prescale_next = prescale_reg;
    tx_next       = tx_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : bit_cnt_reg + 1'b1;
    end

    case (state_reg)
      IDLE: begin
        cnt_next  = '0;
        idx_next  = '0;
        tx_next   = 1'b1;
        busy_next = 1'b0;
`ifdef UART_TX_BREAK_EN
        if (bus.send_break) begin
          state_next    = BRK;
          prescale_next = bus.prescale;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end else
`endif
        if (bus.Data_Valid) begin
          state_next    = START;
          data_next     = bus.P_Data;
          shift_next    = bus.P_Data;
          par_en_next   = bus.par_en;
          par_typ_next  = bus.PAR_TYP;
          stop2_next    = bus.stop2;
          prescale_next = bus.prescale;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == LAST_DATA) begin
            idx_next = '0;
            if (par_en_reg) begin
              state_next = PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            idx_next   = bit_idx_reg + 1'b1;
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          idx_next   = '0;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!stop2_reg || bit_idx_reg == IDX_W'(1)) begin
            state_next = IDLE;
            idx_next   = '0;
            busy_next  = 1'b0;
          end else begin
            idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      // bit_idx counts whole bit periods of low time, saturating at the minimum length.
      BRK: begin
        tx_next   = 1'b0;
        busy_next = 1'b1;
        if (bit_end && bit_idx_reg != BRK_BITS) begin
          idx_next = bit_idx_reg + 1'b1;
        end
        if (!bus.send_break &&
            (bit_idx_reg == BRK_BITS || (bit_idx_reg == BRK_BITS - 1'b1 && bit_end))) begin
          state_next = BRK_STOP;
          cnt_next   = '0;
          idx_next   = '0;
          tx_next    = 1'b1;
        end
      end
      BRK_STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase

    // Pulse lands on the final clock of the last stop bit; a break never reaches STOP.
    done_next = (state_next == STOP) && (cnt_next == p_last) &&
                (stop2_reg ? (idx_next == IDX_W'(1)) : 1'b1);
  end

  assign bus.TX_OUT     = tx_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = done_reg;
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame shapes, parity, stop bits, input stability,
// back-to-back frames and reset behaviour (plus line break when UART_TX_BREAK_EN is set).
module tb_uart_tx_param;
  localparam int DW = 8;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();
  uart_tx_param #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  logic cap_tx   [0:255];
  logic cap_busy [0:255];
  logic cap_done [0:255];

  // Presents a request on a falling edge; returns on the falling edge after acceptance,
  // which is the first clock of the start bit.
  task automatic start_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic s2, input logic [PW-1:0] ps, input bit keep_dv);
    @(negedge clk);
    bus.P_Data     = d;
    bus.par_en     = pe;
    bus.PAR_TYP    = pt;
    bus.stop2      = s2;
    bus.prescale   = ps;
    bus.Data_Valid = 1'b1;
    @(negedge clk);
    if (!keep_dv) bus.Data_Valid = 1'b0;
  endtask

  task automatic capture(input int n, input int poke_at, input int drop_at);
    for (int i = 0; i < n; i++) begin
      cap_tx[i]   = bus.TX_OUT;
      cap_busy[i] = bus.busy;
      cap_done[i] = bus.frame_done;
      if (i == poke_at) begin
        bus.P_Data     = 8'hC3;
        bus.Data_Valid = 1'b1;
      end
      if (i == drop_at) bus.Data_Valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({bus.TX_OUT, bus.busy, bus.frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL reset tx/busy/done got=%b%b%b want=100", bus.TX_OUT, bus.busy, bus.frame_done);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.TX_OUT, bus.busy, bus.frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL idle_after_reset tx/busy/done got=%b%b%b want=100",
               bus.TX_OUT, bus.busy, bus.frame_done);
    end
  endtask

  task automatic test_basic();
    logic [15:0] bits;
    logic [15:0] tmp;
    logic e_tx, e_busy, e_done;
    bits = 16'h034A;  // 0, A5 LSB first, 1
    start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0);
    capture(41, -1, -1);
    for (int i = 0; i < 41; i++) begin
      tmp    = bits >> (i / 4);
      e_tx   = (i < 40) ? tmp[0] : 1'b1;
      e_busy = (i < 40);
      e_done = (i == 39);
      total++;
      if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {e_tx, e_busy, e_done}) begin
        bad++;
        $display("FAIL basic clk=%0d tx/busy/done got=%b%b%b want=%b%b%b", i,
                 cap_tx[i], cap_busy[i], cap_done[i], e_tx, e_busy, e_done);
      end
    end
  endtask

  task automatic test_parity();
    logic [15:0] bits;
    logic [15:0] tmp;
    logic e_tx, e_busy, e_done;
    for (int t = 0; t < 2; t++) begin
      // 07 has three ones: even parity bit 1, odd parity bit 0.
      bits = (t == 0) ? 16'h060E : 16'h040E;
      start_frame(8'h07, 1'b1, t[0], 1'b0, 8'd2, 1'b0);
      capture(23, -1, -1);
      for (int i = 0; i < 23; i++) begin
        tmp    = bits >> (i / 2);
        e_tx   = (i < 22) ? tmp[0] : 1'b1;
        e_busy = (i < 22);
        e_done = (i == 21);
        total++;
        if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {e_tx, e_busy, e_done}) begin
          bad++;
          $display("FAIL parity typ=%0d clk=%0d tx/busy/done got=%b%b%b want=%b%b%b", t, i,
                   cap_tx[i], cap_busy[i], cap_done[i], e_tx, e_busy, e_done);
        end
      end
    end
  endtask

  task automatic test_stop2_prescale0();
    logic [15:0] bits;
    logic [15:0] tmp;
    logic e_tx, e_busy, e_done;
    bits = 16'h07FE;
    start_frame(8'hFF, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0);
    capture(12, -1, -1);
    for (int i = 0; i < 12; i++) begin
      tmp    = bits >> i;
      e_tx   = (i < 11) ? tmp[0] : 1'b1;
      e_busy = (i < 11);
      e_done = (i == 10);
      total++;
      if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {e_tx, e_busy, e_done}) begin
        bad++;
        $display("FAIL stop2 clk=%0d tx/busy/done got=%b%b%b want=%b%b%b", i,
                 cap_tx[i], cap_busy[i], cap_done[i], e_tx, e_busy, e_done);
      end
    end
  endtask

  task automatic test_input_stability();
    logic [15:0] bits;
    logic [15:0] tmp;
    logic e_tx, e_busy, e_done;
    bits = 16'h0278;  // 0, 3C LSB first, 1
    start_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'd2, 1'b0);
    capture(24, 5, 6);
    for (int i = 0; i < 24; i++) begin
      tmp    = bits >> (i / 2);
      e_tx   = (i < 20) ? tmp[0] : 1'b1;
      e_busy = (i < 20);
      e_done = (i == 19);
      total++;
      if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {e_tx, e_busy, e_done}) begin
        bad++;
        $display("FAIL stability clk=%0d tx/busy/done got=%b%b%b want=%b%b%b", i,
                 cap_tx[i], cap_busy[i], cap_done[i], e_tx, e_busy, e_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    logic [15:0] tmp;
    logic e_tx, e_busy, e_done;
    int k;
    bits = 16'h02AA;  // 0, 55 LSB first, 1
    start_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1);
    capture(64, -1, 31);
    for (int i = 0; i < 64; i++) begin
      k = i % 31;
      if (i >= 61 || k == 30) begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end else begin
        tmp    = bits >> (k / 3);
        e_tx   = tmp[0];
        e_busy = 1'b1;
        e_done = (k == 29);
      end
      total++;
      if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {e_tx, e_busy, e_done}) begin
        bad++;
        $display("FAIL back_to_back clk=%0d tx/busy/done got=%b%b%b want=%b%b%b", i,
                 cap_tx[i], cap_busy[i], cap_done[i], e_tx, e_busy, e_done);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] bits;
    logic [15:0] tmp;
    logic e_tx, e_busy, e_done;
    start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0);
    capture(18, -1, -1);
    total++;
    if ({bus.TX_OUT, bus.busy} !== 2'b01) begin
      bad++;
      $display("FAIL pre_reset_bit3 tx/busy got=%b%b want=01", bus.TX_OUT, bus.busy);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({bus.TX_OUT, bus.busy, bus.frame_done} !== 3'b100) begin
      bad++;
      $display("FAIL async_reset tx/busy/done got=%b%b%b want=100",
               bus.TX_OUT, bus.busy, bus.frame_done);
    end
    @(negedge clk);
    reset = 1'b1;
    bits = 16'h02B4;  // 0, 5A LSB first, 1
    start_frame(8'h5A, 1'b0, 1'b0, 1'b0, 8'd1, 1'b0);
    capture(11, -1, -1);
    for (int i = 0; i < 11; i++) begin
      tmp    = bits >> i;
      e_tx   = (i < 10) ? tmp[0] : 1'b1;
      e_busy = (i < 10);
      e_done = (i == 9);
      total++;
      if ({cap_tx[i], cap_busy[i], cap_done[i]} !== {e_tx, e_busy, e_done}) begin
        bad++;
        $display("FAIL post_reset clk=%0d tx/busy/done got=%b%b%b want=%b%b%b", i,
                 cap_tx[i], cap_busy[i], cap_done[i], e_tx, e_busy, e_done);
      end
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic e_tx, e_busy;
    @(negedge clk);
    bus.prescale   = 8'd4;
    bus.send_break = 1'b1;
    for (int i = 1; i <= 105; i++) begin
      @(negedge clk);
      e_tx   = (i > 100);
      e_busy = (i <= 104);
      total++;
      if ({bus.TX_OUT, bus.busy, bus.frame_done} !== {e_tx, e_busy, 1'b0}) begin
        bad++;
        $display("FAIL break clk=%0d tx/busy/done got=%b%b%b want=%b%b0", i,
                 bus.TX_OUT, bus.busy, bus.frame_done, e_tx, e_busy);
      end
      if (i == 100) bus.send_break = 1'b0;
    end
  endtask
`endif

  initial begin
    bus.Data_Valid = 1'b0;
    bus.P_Data     = '0;
    bus.par_en     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.stop2      = 1'b0;
    bus.prescale   = '0;
`ifdef UART_TX_BREAK_EN
    bus.send_break = 1'b0;
`endif
    test_reset();
    test_basic();
    test_parity();
    test_stop2_prescale0();
    test_input_stability();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, the successor to the fixed-rate serializer/parity/FSM transmitter.
- Frame: 1 start bit, DATA_WIDTH data bits sent LSB first, optional parity bit, 1 or 2 stop bits.
- An internal baud prescaler sets bit length in system clocks, so no external baud clock is needed.
- Sits between a register/byte source (Data_Valid handshake) and the serial line pin TX_OUT.

Parameters:
DATA_WIDTH, 8, data bits per frame (range 5..16).
PRESCALE_WIDTH, 8, width of the prescale input (clocks per bit).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
Data_Valid  input  1  request to send P_Data; sampled only in IDLE.
P_Data  input  DATA_WIDTH  parallel data word.
par_en  input  1  1 = parity bit inserted.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
stop2  input  1  1 = two stop bits, 0 = one stop bit.
prescale  input  PRESCALE_WIDTH  clocks per bit; 0 is treated as 1.
TX_OUT  output  1  serial line, registered; idle high.
busy  output  1  high while a frame is in progress.
frame_done  output  1  one-clock pulse on the last clock of the final stop bit.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE, TX_OUT = 1, busy = 0, frame_done = 0, all counters 0, shadow registers 0.
- Acceptance: in IDLE with Data_Valid = 1 at a clock edge, the block latches P_Data, par_en, PAR_TYP, stop2 and prescale into shadow registers. On that same edge: TX_OUT goes to 0 (start bit), busy goes to 1. Latency from Data_Valid sampled to start bit is 1 clock.
- Input changes after acceptance have no effect on the current frame. Data_Valid outside IDLE is ignored; no queuing.
- Bit timing: a bit counter counts 0..P-1, where P = max(latched prescale, 1). Each bit is held on TX_OUT for exactly P clocks. The counter clears at every bit boundary.
- State machine: IDLE -> START (1 bit) -> DATA (DATA_WIDTH bits, index 0 first) -> PARITY (1 bit, only if par_en latched) -> STOP (1 or 2 bits) -> IDLE.
- Parity bit: XOR of all latched data bits when PAR_TYP = 0; inverse of that XOR when PAR_TYP = 1. Computed from the latched word, not from live P_Data.
- Stop bits: TX_OUT = 1 for P clocks, or 2*P clocks when stop2 was latched.
- Frame end: frame_done = 1 on the last clock of the final stop bit. The next edge returns the FSM to IDLE with busy = 0.
- Back-to-back: the minimum gap between frames is 1 IDLE clock. A new frame whose Data_Valid is sampled in that IDLE clock starts its start bit on the following edge.
- Total frame length: P*(1 + DATA_WIDTH + par_en + 1 + stop2) clocks, measured from the first start-bit clock to the last stop-bit clock.
- Reset mid-frame: the frame aborts immediately, TX_OUT returns to 1, and outputs take their reset values.
- busy is registered; it is never asserted in IDLE and never deasserted before frame_done.

Optional Feature:
Macro: UART_TX_BREAK_EN.
- Defined: adds input send_break (1 bit) and a BREAK state.
  - In IDLE, send_break = 1 takes priority over Data_Valid and moves to BREAK.
  - In BREAK: TX_OUT = 0 and busy = 1 for as long as send_break stays high, with a minimum of P*(DATA_WIDTH+3) clocks.
  - Exit from BREAK: one stop period of P clocks with TX_OUT = 1, then IDLE. frame_done is not pulsed for a break.
- Not defined: no send_break port, no BREAK state; behaviour is exactly as above.

Test Plan:
- Basic frame: DATA_WIDTH = 8, prescale = 4, par_en = 0, stop2 = 0, P_Data = 8'hA5. Response: TX_OUT = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 4 clocks. busy high for 40 clocks. frame_done pulses at clock 40.
- Parity: P_Data = 8'h07, par_en = 1. With PAR_TYP = 0 the parity bit is 1; with PAR_TYP = 1 it is 0. Frame length with prescale = 2 is 22 clocks.
- Two stop bits with prescale = 0: stop2 = 1, P_Data = 8'hFF. Each bit lasts 1 clock (0 treated as 1). Stop high for 2 clocks. Frame length 11 clocks.
- Input stability: change P_Data from 8'h3C to 8'hC3 and pulse Data_Valid mid-frame. Response: the serial stream is still 8'h3C, and no second frame starts.
- Back-to-back: hold Data_Valid high continuously with prescale = 3. Response: frames separated by exactly 1 idle-high clock; busy low for exactly 1 clock between frames.
- Reset mid-frame: assert reset = 0 during data bit 3. Response: TX_OUT = 1 and busy = 0 asynchronously (before the next clock edge). After release, the next Data_Valid starts a clean frame. With UART_TX_BREAK_EN, additionally check that send_break held for 100 clocks at prescale = 4 gives TX_OUT low for 100 clocks, then high for 4 clocks, then IDLE.
